// File: rtl/genaxis_pkg.sv
// Shared types for the AXIS descriptor generator: field modes and FSM states.
package genaxis_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_RANDOM = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GET  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // RANDOM and SWEEP fields are the ones that care about min/max.
  function automatic logic is_ranged(input logic [1:0] mode);
    return (mode == MODE_RANDOM) || (mode == MODE_SWEEP);
  endfunction

endpackage

// File: rtl/genaxis_field_sel.sv
// One descriptor field: latches its mode/range at start and produces a value
// that is fixed, a range-filtered random sample, or a wrapping sweep.
module genaxis_field_sel
  import genaxis_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_get,
  input  logic         i_adv,
  input  logic [1:0]   i_mode,
  input  logic [W-1:0] i_fixed,
  input  logic [W-1:0] i_min,
  input  logic [W-1:0] i_max,
  input  logic [W-1:0] i_rnd,
  output logic [W-1:0] o_value,
  output logic         o_ready
);

  logic [1:0]   r_mode;
  logic [W-1:0] r_min;
  logic [W-1:0] r_max;
  logic [W-1:0] r_val;
  logic         r_got;
  logic         w_rnd_ok;

  assign w_rnd_ok = (i_rnd >= r_min) && (i_rnd <= r_max);
  assign o_value  = r_val;
  assign o_ready  = (r_mode != MODE_RANDOM) || r_got;

  // Latch controls on start, capture first in-range random, advance sweep on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= '0;
      r_min  <= '0;
      r_max  <= '0;
      r_val  <= '0;
      r_got  <= 1'b0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_min  <= i_min;
      r_max  <= i_max;
      r_got  <= 1'b0;
      if (i_mode == MODE_SWEEP)       r_val <= i_min;
      else if (i_mode == MODE_RANDOM) r_val <= '0;
      else                            r_val <= i_fixed;
    end else if (i_adv) begin
      r_got <= 1'b0;
      if (r_mode == MODE_SWEEP)
        r_val <= (r_val == r_max) ? r_min : r_val + W'(1);
    end else if (i_get && (r_mode == MODE_RANDOM) && !r_got && w_rnd_ok) begin
      r_val <= i_rnd;
      r_got <= 1'b1;
    end
  end

endmodule

// File: rtl/genaxis_descriptor_gen_v2.sv
// AXIS descriptor generator: builds {seq, channel, pause, length} descriptors
// from three configurable fields and streams them with valid/ready.
//
//   state | meaning
//   IDLE  | waiting for an acceptable start
//   GET   | collecting field values (random fields may need several cycles)
//   SEND  | descriptor presented, valid held until handshake
module genaxis_descriptor_gen_v2
  import genaxis_pkg::*;
#(
  parameter int ID_WIDTH    = 10,
  parameter int LEN_WIDTH   = 16,
  parameter int PAUSE_WIDTH = 32,
  parameter int SEQ_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cntrl_start_i,
  input  logic                   cntrl_stop_i,
  input  logic [1:0]             cntrl_len_mode_i,
  input  logic [1:0]             cntrl_ch_mode_i,
  input  logic [1:0]             cntrl_pause_mode_i,
  input  logic                   cntrl_use_limit_i,
  input  logic [31:0]            cntrl_cnt_packet_i,
  input  logic [LEN_WIDTH-1:0]   cntrl_fixed_length_i,
  input  logic [LEN_WIDTH-1:0]   cntrl_min_length_i,
  input  logic [LEN_WIDTH-1:0]   cntrl_max_length_i,
  input  logic [ID_WIDTH-1:0]    cntrl_fixed_channel_i,
  input  logic [ID_WIDTH-1:0]    cntrl_min_channel_i,
  input  logic [ID_WIDTH-1:0]    cntrl_max_channel_i,
  input  logic [PAUSE_WIDTH-1:0] cntrl_fixed_pause_i,
  input  logic [PAUSE_WIDTH-1:0] cntrl_min_pause_i,
  input  logic [PAUSE_WIDTH-1:0] cntrl_max_pause_i,
  input  logic [LEN_WIDTH-1:0]   rnd_length_i,
  input  logic [ID_WIDTH-1:0]    rnd_channel_i,
  input  logic [PAUSE_WIDTH-1:0] rnd_pause_i,
  output logic [SEQ_WIDTH+ID_WIDTH+PAUSE_WIDTH+LEN_WIDTH-1:0] descriptor_data_o,
  output logic                   descriptor_valid_o,
  input  logic                   descriptor_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            sent_cnt_o
);

  localparam int DW = SEQ_WIDTH + ID_WIDTH + PAUSE_WIDTH + LEN_WIDTH;

  state_e                 r_state, w_state_nxt;
  logic                   r_valid, r_done, r_stop_pend, r_use_limit;
  logic [31:0]            r_cnt_packet, r_sent, w_sent_inc;
  logic [SEQ_WIDTH-1:0]   r_seq;
  logic [DW-1:0]          r_data;
  logic                   w_done_nxt, w_hs, w_load, w_start_ok, w_all_ready;
  logic                   w_len_nz, w_ranges_ok, w_limit_ok, w_get;
  logic                   w_rdy_len, w_rdy_ch, w_rdy_pause;
  logic [LEN_WIDTH-1:0]   w_len;
  logic [ID_WIDTH-1:0]    w_ch;
  logic [PAUSE_WIDTH-1:0] w_pause;

  // Start qualification is evaluated on the live control inputs, before latching.
  assign w_len_nz    = is_ranged(cntrl_len_mode_i) ? (cntrl_min_length_i != '0)
                                                   : (cntrl_fixed_length_i != '0);
  assign w_ranges_ok = (!is_ranged(cntrl_len_mode_i)   || (cntrl_max_length_i  >= cntrl_min_length_i))
                    && (!is_ranged(cntrl_ch_mode_i)    || (cntrl_max_channel_i >= cntrl_min_channel_i))
                    && (!is_ranged(cntrl_pause_mode_i) || (cntrl_max_pause_i   >= cntrl_min_pause_i));
  assign w_limit_ok  = !cntrl_use_limit_i || (cntrl_cnt_packet_i != 32'd0);
  assign w_start_ok  = cntrl_start_i && !cntrl_stop_i && w_limit_ok && w_ranges_ok && w_len_nz;
  assign w_load      = (r_state == ST_IDLE) && w_start_ok;
  assign w_get       = (r_state == ST_GET);
  assign w_hs        = r_valid && descriptor_ready_i;
  assign w_all_ready = w_rdy_len && w_rdy_ch && w_rdy_pause;
  assign w_sent_inc  = (&r_sent) ? r_sent : r_sent + 32'd1;

  assign descriptor_data_o  = r_data;
  assign descriptor_valid_o = r_valid;
  assign busy_o             = (r_state != ST_IDLE);
  assign done_o             = r_done;
  assign sent_cnt_o         = r_sent;

  genaxis_field_sel #(.W(LEN_WIDTH)) u_len (
    .clk(clk), .reset(reset), .i_load(w_load), .i_get(w_get), .i_adv(w_hs),
    .i_mode(cntrl_len_mode_i), .i_fixed(cntrl_fixed_length_i),
    .i_min(cntrl_min_length_i), .i_max(cntrl_max_length_i), .i_rnd(rnd_length_i),
    .o_value(w_len), .o_ready(w_rdy_len)
  );

  genaxis_field_sel #(.W(ID_WIDTH)) u_ch (
    .clk(clk), .reset(reset), .i_load(w_load), .i_get(w_get), .i_adv(w_hs),
    .i_mode(cntrl_ch_mode_i), .i_fixed(cntrl_fixed_channel_i),
    .i_min(cntrl_min_channel_i), .i_max(cntrl_max_channel_i), .i_rnd(rnd_channel_i),
    .o_value(w_ch), .o_ready(w_rdy_ch)
  );

  genaxis_field_sel #(.W(PAUSE_WIDTH)) u_pause (
    .clk(clk), .reset(reset), .i_load(w_load), .i_get(w_get), .i_adv(w_hs),
    .i_mode(cntrl_pause_mode_i), .i_fixed(cntrl_fixed_pause_i),
    .i_min(cntrl_min_pause_i), .i_max(cntrl_max_pause_i), .i_rnd(rnd_pause_i),
    .o_value(w_pause), .o_ready(w_rdy_pause)
  );

  // Next-state and done decode; stop in GET aborts, stop in SEND waits for handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_GET;
      ST_GET: begin
        if (cntrl_stop_i)     w_state_nxt = ST_IDLE;
        else if (w_all_ready) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (r_use_limit && (w_sent_inc == r_cnt_packet)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_stop_pend || cntrl_stop_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_GET;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters, pending stop and the registered descriptor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_use_limit  <= 1'b0;
      r_cnt_packet <= '0;
      r_sent       <= '0;
      r_seq        <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == ST_SEND);
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_use_limit  <= cntrl_use_limit_i;
        r_cnt_packet <= cntrl_cnt_packet_i;
        r_seq        <= '0;
        r_sent       <= '0;
      end else if (w_hs) begin
        r_seq  <= r_seq + SEQ_WIDTH'(1);
        r_sent <= w_sent_inc;
      end
      if (w_state_nxt == ST_IDLE)
        r_stop_pend <= 1'b0;
      else if ((r_state == ST_SEND) && cntrl_stop_i)
        r_stop_pend <= 1'b1;
      if ((r_state == ST_GET) && (w_state_nxt == ST_SEND))
        r_data <= {r_seq, w_ch, w_pause, w_len};
    end
  end

endmodule

// File: tb/tb_genaxis_descriptor_gen_v2.sv
// Directed bench for genaxis_descriptor_gen_v2 with hand-computed expectations.
module tb_genaxis_descriptor_gen_v2;

  logic        clk, reset;
  logic        start, stop, use_limit, ready;
  logic [1:0]  len_mode, ch_mode, pause_mode;
  logic [31:0] cnt_packet;
  logic [15:0] fix_len, min_len, max_len, rnd_len;
  logic [9:0]  fix_ch, min_ch, max_ch, rnd_ch;
  logic [31:0] fix_pause, min_pause, max_pause, rnd_pause;
  logic [73:0] data;
  logic        valid, busy, done;
  logic [31:0] sent;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done;
  int lat;
  int n_bad;
  logic [73:0] q_data[$];
  int          q_cyc[$];
  logic [73:0] d0;
  logic [9:0]  rnd_seq [8];

  genaxis_descriptor_gen_v2 dut (
    .clk(clk), .reset(reset),
    .cntrl_start_i(start), .cntrl_stop_i(stop),
    .cntrl_len_mode_i(len_mode), .cntrl_ch_mode_i(ch_mode), .cntrl_pause_mode_i(pause_mode),
    .cntrl_use_limit_i(use_limit), .cntrl_cnt_packet_i(cnt_packet),
    .cntrl_fixed_length_i(fix_len), .cntrl_min_length_i(min_len), .cntrl_max_length_i(max_len),
    .cntrl_fixed_channel_i(fix_ch), .cntrl_min_channel_i(min_ch), .cntrl_max_channel_i(max_ch),
    .cntrl_fixed_pause_i(fix_pause), .cntrl_min_pause_i(min_pause), .cntrl_max_pause_i(max_pause),
    .rnd_length_i(rnd_len), .rnd_channel_i(rnd_ch), .rnd_pause_i(rnd_pause),
    .descriptor_data_o(data), .descriptor_valid_o(valid), .descriptor_ready_i(ready),
    .busy_o(busy), .done_o(done), .sent_cnt_o(sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic [15:0] s, input logic [9:0] c,
                                     input logic [31:0] p, input logic [15:0] l);
    return {s, c, p, l};
  endfunction

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    start = 0; stop = 0; use_limit = 0; cnt_packet = 0; ready = 1;
    len_mode = 2'd0; ch_mode = 2'd0; pause_mode = 2'd0;
    fix_len = 16'd64; min_len = 0; max_len = 0; rnd_len = 0;
    fix_ch = 10'd3; min_ch = 0; max_ch = 0; rnd_ch = 0;
    fix_pause = 32'd10; min_pause = 0; max_pause = 0; rnd_pause = 0;
  endtask

  task automatic start_pulse();
    start = 1;
    tick();
    start = 0;
  endtask

  // Ticks until valid is seen; drives the channel random source per GET cycle.
  task automatic wait_valid(input int budget, output int l);
    l = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (valid) begin
        l = k;
        break;
      end
      rnd_ch = (k < 8) ? rnd_seq[k] : 10'd5;
    end
  endtask

  task automatic collect(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (valid && ready) begin
        q_data.push_back(data);
        q_cyc.push_back(i);
      end
      if (done) n_done++;
      tick();
    end
  endtask

  initial begin
    rnd_seq[0] = 10'd7; rnd_seq[1] = 10'd9; rnd_seq[2] = 10'd4;
    for (int i = 3; i < 8; i++) rnd_seq[i] = 10'd5;
    defaults();
    reset = 1;
    tick(); tick();
    chk("rst_valid", 74'(valid), 74'd0);
    chk("rst_busy",  74'(busy),  74'd0);
    chk("rst_done",  74'(done),  74'd0);
    chk("rst_sent",  74'(sent),  74'd0);
    chk("rst_data",  data,       74'd0);
    reset = 0;
    tick();

    // All FIXED, limit 4, ready high
    use_limit = 1; cnt_packet = 4;
    q_data.delete(); q_cyc.delete(); n_done = 0;
    start_pulse();
    collect(20);
    chk("fix_count", 74'(q_data.size()), 74'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fix_desc%0d", i), (i < q_data.size()) ? q_data[i] : 74'd0,
          mk(16'(i), 10'd3, 32'd10, 16'd64));
    chk("fix_tput", 74'((q_cyc.size() > 1) ? q_cyc[1] - q_cyc[0] : 0), 74'd2);
    chk("fix_done_once", 74'(n_done), 74'd1);
    chk("fix_busy_end", 74'(busy), 74'd0);
    chk("fix_sent", 74'(sent), 74'd4);

    // Length sweep 10..12, pause sweep at all-ones boundary, limit 5
    defaults();
    use_limit = 1; cnt_packet = 5;
    len_mode = 2'd2; min_len = 16'd10; max_len = 16'd12;
    pause_mode = 2'd2; min_pause = 32'hFFFF_FFFE; max_pause = 32'hFFFF_FFFF;
    q_data.delete(); q_cyc.delete(); n_done = 0;
    start_pulse();
    collect(24);
    chk("swp_count", 74'(q_data.size()), 74'd5);
    chk("swp_d0", (q_data.size() > 0) ? q_data[0] : 74'd0, mk(16'd0, 10'd3, 32'hFFFF_FFFE, 16'd10));
    chk("swp_d1", (q_data.size() > 1) ? q_data[1] : 74'd0, mk(16'd1, 10'd3, 32'hFFFF_FFFF, 16'd11));
    chk("swp_d2", (q_data.size() > 2) ? q_data[2] : 74'd0, mk(16'd2, 10'd3, 32'hFFFF_FFFE, 16'd12));
    chk("swp_d3", (q_data.size() > 3) ? q_data[3] : 74'd0, mk(16'd3, 10'd3, 32'hFFFF_FFFF, 16'd10));
    chk("swp_d4", (q_data.size() > 4) ? q_data[4] : 74'd0, mk(16'd4, 10'd3, 32'hFFFF_FFFE, 16'd11));
    chk("swp_done", 74'(n_done), 74'd1);
    chk("swp_sent", 74'(sent), 74'd5);

    // Latency: FIXED reference, then channel RANDOM with 7, 9, 4
    defaults();
    use_limit = 1; cnt_packet = 1;
    start_pulse();
    wait_valid(10, lat);
    chk("lat_fixed", 74'(lat), 74'd1);
    tick(); tick(); tick();
    ch_mode = 2'd1; min_ch = 10'd2; max_ch = 10'd5; rnd_ch = 10'd7;
    start_pulse();
    wait_valid(12, lat);
    chk("lat_random", 74'(lat), 74'd4);
    chk("rnd_desc", data, mk(16'd0, 10'd4, 32'd10, 16'd64));
    tick(); tick(); tick();

    // Backpressure with stop during SEND
    defaults();
    ready = 0;
    start_pulse();
    wait_valid(10, lat);
    chk("bp_first_valid", 74'(lat), 74'd1);
    d0 = data;
    chk("bp_data", d0, mk(16'd0, 10'd3, 32'd10, 16'd64));
    stop = 1;
    tick();
    stop = 0;
    n_bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (!valid || data !== d0) n_bad++;
      tick();
    end
    chk("bp_hold", 74'(n_bad), 74'd0);
    ready = 1;
    tick();
    chk("bp_sent", 74'(sent), 74'd1);
    chk("bp_busy", 74'(busy), 74'd0);
    chk("bp_valid_off", 74'(valid), 74'd0);
    n_done = 0;
    collect(4);
    chk("bp_no_done", 74'(n_done), 74'd0);

    // Rejected starts
    defaults();
    len_mode = 2'd2; min_len = 16'd20; max_len = 16'd10;
    start_pulse(); tick();
    chk("rej_range", 74'(busy), 74'd0);
    defaults();
    use_limit = 1; cnt_packet = 0;
    start_pulse(); tick();
    chk("rej_cnt0", 74'(busy), 74'd0);
    defaults();
    fix_len = 16'd0;
    start_pulse(); tick();
    chk("rej_len0", 74'(busy), 74'd0);
    defaults();
    stop = 1;
    start_pulse(); stop = 0; tick();
    chk("rej_stop_wins", 74'(busy), 74'd0);

    // Reset while valid is high
    defaults();
    start_pulse();
    for (int i = 0; i < 5; i++) tick();
    ready = 0;
    wait_valid(6, lat);
    chk("rs_valid_pre", 74'(valid), 74'd1);
    chk("rs_sent_pre", 74'(sent), 74'd2);
    reset = 1;
    #1;
    chk("rs_valid_async", 74'(valid), 74'd0);
    chk("rs_sent", 74'(sent), 74'd0);
    chk("rs_data", data, 74'd0);
    tick();
    reset = 0;
    ready = 1;
    n_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid) n_bad++;
      tick();
    end
    chk("rs_quiet", 74'(n_bad), 74'd0);
    use_limit = 1; cnt_packet = 1;
    start_pulse();
    wait_valid(10, lat);
    chk("rs_restart", data, mk(16'd0, 10'd3, 32'd10, 16'd64));
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/genaxis_descriptor_gen_v2.md
GENAXIS_DESCRIPTOR_GEN_V2 -- requirements
Module: genaxis_descriptor_gen_v2

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 10, channel width; LEN_WIDTH, default 16, length width; PAUSE_WIDTH, default 32, pause width; SEQ_WIDTH, default 16, sequence-number width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- cntrl_start_i  in  1  start request
- cntrl_stop_i  in  1  stop request
- cntrl_len_mode_i  in  2  length field mode
- cntrl_ch_mode_i  in  2  channel field mode
- cntrl_pause_mode_i  in  2  pause field mode
- cntrl_use_limit_i  in  1  stop after cntrl_cnt_packet_i descriptors
- cntrl_cnt_packet_i  in  32  descriptor limit
- cntrl_{fixed,min,max}_length_i  in  LEN_WIDTH  length settings
- cntrl_{fixed,min,max}_channel_i  in  ID_WIDTH  channel settings
- cntrl_{fixed,min,max}_pause_i  in  PAUSE_WIDTH  pause settings
- rnd_length_i / rnd_channel_i / rnd_pause_i  in  LEN/ID/PAUSE_WIDTH  external random sources
- descriptor_data_o  out  SEQ+ID+PAUSE+LEN_WIDTH  {seq, channel, pause, length}, length in the LSBs
- descriptor_valid_o  out  1  AXIS valid
- descriptor_ready_i  in  1  AXIS ready
- busy_o  out  1  high when not IDLE
- done_o  out  1  one-cycle pulse when the limit is reached
- sent_cnt_o  out  32  descriptors accepted since the last start

Function
REQ-003 Field modes SHALL be: 0 FIXED (fixed value); 1 RANDOM (rnd input, accepted only if min <= rnd <= max); 2 SWEEP (min, then +1 per accepted descriptor, max wraps to min); 3 treated as FIXED.
REQ-004 The FSM SHALL have states IDLE, GET, SEND.
REQ-005 In IDLE, start SHALL move to GET only if all of the following hold: (limit off or cnt > 0); every RANDOM/SWEEP field has max >= min; the length is non-zero (fixed > 0 in FIXED, min > 0 otherwise). Otherwise start SHALL be ignored.
REQ-006 On an accepted start, all cntrl_* inputs SHALL be latched, and the latched copies SHALL be used until the next return to IDLE.
REQ-007 Start SHALL set seq to 0, sent_cnt_o to 0, and every SWEEP field value to its min.
REQ-008 In GET, each RANDOM field SHALL sample its rnd input every cycle until the first in-range value, then hold that value. FIXED and SWEEP fields SHALL be ready in the first GET cycle.
REQ-009 GET SHALL move to SEND in the cycle after all fields are ready. Minimum GET dwell is 1 cycle.
REQ-010 descriptor_valid_o SHALL be registered and high exactly in SEND. Data SHALL be stable while valid is high and ready is low.
REQ-011 On handshake (valid & ready): seq += 1 with modulo 2^SEQ_WIDTH wrap; sent_cnt_o += 1 (saturating at 2^32-1); each SWEEP field advances.
REQ-012 After a handshake, the FSM SHALL go to IDLE with done_o = 1 for one cycle if the limit is on and sent equals cnt. Otherwise it SHALL go to IDLE if a stop is pending, and to GET otherwise.
REQ-013 Stop in GET SHALL go to IDLE on the next edge with no descriptor emitted.
REQ-014 Stop in SEND SHALL be recorded as pending, and valid SHALL be held until the handshake (AXIS-compliant, never withdrawn).
REQ-015 A pending stop SHALL be cleared on entry to IDLE. Start and stop together in IDLE: stop wins.
REQ-016 Start asserted outside IDLE SHALL be ignored.
REQ-017 Back-to-back throughput SHALL be one descriptor per 2 cycles with FIXED/SWEEP fields and ready held high.
REQ-018 Comparisons SHALL be unsigned at the native field width. SWEEP increment SHALL be at field width, with the max == all-ones case wrapping to min.

Reset
REQ-019 Reset SHALL force: state IDLE; descriptor_valid_o 0; busy_o 0; done_o 0; sent_cnt_o 0; seq 0; pending stop 0; all latched controls 0; descriptor_data_o 0.
REQ-020 Reset asserted mid-SEND SHALL drop valid asynchronously. No descriptor SHALL be emitted after release until a new start.

Structure
REQ-021 The mode encoding enum and the FSM state enum SHALL live in the shared package genaxis_pkg.
REQ-022 A sub-module genaxis_field_sel, parametrised by width, SHALL implement one field's mode/range/sweep logic and be instantiated three times.

Verification
REQ-023 All FIXED, len=64, ch=3, pause=10, limit 4, ready=1 -> 4 descriptors with seq 0..3, done_o pulse once, busy_o falls, sent_cnt_o=4.
REQ-024 Length SWEEP min=10, max=12, limit 5 -> lengths 10, 11, 12, 10, 11.
REQ-025 Channel RANDOM min=2, max=5, rnd sequence 7, 9, 4 -> descriptor channel=4, emitted 3 GET cycles later than the FIXED case.
REQ-026 Ready held 0 for 20 cycles with stop pulsed during SEND -> valid held, data constant; after ready=1, exactly one handshake, then IDLE, no done_o.
REQ-027 Start with auto length min=20, max=10, or limit on with cnt=0 -> stays IDLE, busy_o=0.
REQ-028 Reset asserted during SEND with valid=1 -> valid 0 immediately, sent_cnt_o=0; a restart produces seq 0.
